parity_serial_rx: RTL and testbench

//  Serial receiver and even-parity checker for 4-bit codewords produced by the even-parity generator.

---
 rtl/parity_serial_rx.sv | 92 +++++++++
 tb/tb_parity_serial_rx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/parity_serial_rx.sv
// parity_serial_rx: LSB-first serial receiver with even-parity and framing checks and a saturating error count.
module parity_serial_rx #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              clr_count,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);
  localparam int BW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              par_q, par_d, perr_q, perr_d, ferr_q, ferr_d, valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frame_bad;
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    valid_d   = 1'b0;
    cnt_d     = cnt_q;
    frame_bad = (^shift_q ^ par_q) | ~serial_in;
    case (state_q)
      IDLE: begin
        state_d   = serial_in ? IDLE : DATA;
        bit_cnt_d = '0;
      end
      DATA: begin
        shift_d[bit_cnt_q] = serial_in;
        bit_cnt_d = bit_cnt_q + 1'b1;
        state_d   = (bit_cnt_q == BW'(DATA_W - 1)) ? PARITY : DATA;
      end
      PARITY: begin
        par_d   = serial_in;
        state_d = STOP;
      end
      STOP: begin
        // a 0 stop bit is reported, never reinterpreted as the next start bit
        data_d  = shift_q;
        perr_d  = ^shift_q ^ par_q;
        ferr_d  = ~serial_in;
        valid_d = 1'b1;
        cnt_d   = (frame_bad && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr_count) cnt_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign err_count  = cnt_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_parity_serial_rx.sv
// tb_parity_serial_rx: directed and random frames into two receivers (8-bit and 2-bit error counters),
// compared every cycle against a bit-history reference model.
module tb_parity_serial_rx;
  logic clk = 1'b0, rst_n = 1'b0, serial_in = 1'b1, clr_count = 1'b0;
  logic [3:0] d8, d2;
  logic v8, v2, pe8, pe2, fe8, fe2, b8, b2;
  logic [7:0] c8;
  logic [1:0] c2;
  int checks = 0, passed = 0;

  parity_serial_rx #(.DATA_W(4), .CNT_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .clr_count(clr_count),
    .data_out(d8), .data_valid(v8), .parity_err(pe8), .frame_err(fe8), .err_count(c8), .busy(b8));
  parity_serial_rx #(.DATA_W(4), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .clr_count(clr_count),
    .data_out(d2), .data_valid(v2), .parity_err(pe2), .frame_err(fe2), .err_count(c2), .busy(b2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: remember every sampled line bit; a frame is the 7 bits starting at a 0 seen while idle.
  int bits[$];
  int start = -1, n, ones;
  int m_data = 0, m_pe = 0, m_fe = 0, m_valid = 0, m_busy = 0, m_c8 = 0, m_c2 = 0;
  bit m_bad;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits.delete();
      start = -1;
      m_data = 0; m_pe = 0; m_fe = 0; m_valid = 0; m_busy = 0; m_c8 = 0; m_c2 = 0;
    end else begin
      bits.push_back(int'(serial_in));
      n = bits.size() - 1;
      m_valid = 0;
      m_bad = 0;
      if (start < 0) begin
        if (serial_in == 1'b0) start = n;
      end else if (n == start + 6) begin
        m_data = 0;
        ones = 0;
        for (int k = 0; k < 4; k++) begin
          m_data += bits[start + 1 + k] << k;
          ones += bits[start + 1 + k];
        end
        m_pe = (ones + bits[start + 5]) % 2;
        m_fe = (bits[start + 6] == 0) ? 1 : 0;
        m_valid = 1;
        m_bad = (m_pe != 0) || (m_fe != 0);
        start = -1;
      end
      if (clr_count) begin
        m_c8 = 0;
        m_c2 = 0;
      end else if (m_bad) begin
        m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
        m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
      end
      m_busy = (start >= 0) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    chk("valid8", v8, m_valid);
    chk("busy8", b8, m_busy);
    chk("data8", d8, m_data);
    chk("perr8", pe8, m_pe);
    chk("ferr8", fe8, m_fe);
    chk("cnt8", c8, m_c8);
    chk("valid2", v2, m_valid);
    chk("data2", d2, m_data);
    chk("cnt2", c2, m_c2);
  end

  task automatic send(input logic [3:0] d, input logic p, input logic s, input logic clr);
    for (int k = 0; k < 7; k++) begin
      serial_in = (k == 0) ? 1'b0 : (k < 5) ? d[k-1] : (k == 5) ? p : s;
      clr_count = (k == 6) & clr;
      @(negedge clk);
    end
    serial_in = 1'b1;
    clr_count = 1'b0;
  endtask

  task automatic idle(input int cycles);
    serial_in = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    logic [3:0] rd;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(20);
    chk("t1_cnt", c8, 0);
    chk("t1_busy", b8, 0);
    send(4'hD, 1'b1, 1'b1, 1'b0);
    chk("t2_valid", v8, 1);
    chk("t2_data", d8, 13);
    chk("t2_perr", pe8, 0);
    chk("t2_ferr", fe8, 0);
    idle(3);
    send(4'hA, 1'b1, 1'b1, 1'b0);
    chk("t3_perr", pe8, 1);
    chk("t3_ferr", fe8, 0);
    chk("t3_cnt", c8, 1);
    clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    chk("t3_clr", c8, 0);
    idle(2);
    send(4'h6, 1'b0, 1'b0, 1'b0);
    chk("t4_data", d8, 6);
    chk("t4_ferr", fe8, 1);
    chk("t4_perr", pe8, 0);
    chk("t4_cnt", c8, 1);
    idle(2);
    send(4'h3, 1'b0, 1'b1, 1'b0);
    chk("t4_next_ferr", fe8, 0);
    chk("t4_next_valid", v8, 1);
    idle(2);
    send(4'h9, 1'b0, 1'b1, 1'b0);
    chk("t5_valid_a", v8, 1);
    chk("t5_data_a", d8, 9);
    send(4'hF, 1'b0, 1'b1, 1'b0);
    chk("t5_valid_b", v8, 1);
    chk("t5_data_b", d8, 15);
    chk("t5_perr_b", pe8, 0);
    idle(2);
    serial_in = 1'b0;
    @(negedge clk);
    serial_in = 1'b1;
    @(negedge clk);
    serial_in = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    serial_in = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", b8, 0);
    chk("t6_rst_cnt", c8, 0);
    #2 rst_n = 1'b1;
    idle(2);
    send(4'hB, 1'b1, 1'b1, 1'b0);
    chk("t6_data", d8, 11);
    chk("t6_perr", pe8, 0);
    for (int i = 0; i < 5; i++) begin
      rd = 4'(i + 1);
      send(rd, ~^rd, 1'b1, 1'b0);
      idle(1);
    end
    chk("t6_sat2", c2, 3);
    chk("t6_cnt8", c8, 5);
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) begin
        clr_count = ($urandom_range(0, 19) == 0);
        @(negedge clk);
      end
      clr_count = 1'b0;
      rd = 4'($urandom);
      send(rd, (^rd) ^ ($urandom_range(0, 4) == 0), $urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0);
    end
    idle(5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
